gate_sweep_ctrl: RTL and testbench

Sequencer and self-checker for the two-input NAND/NOR gate unit. On `start` it drives the gate inputs through all four input combinations, holds each for a programmable settle time and samples the 2-bit gate result. It compares each sample against the expected truth table and reports a pass flag, a per-vector failure mask and a saturating error count. It sits between a test/control host and one gate unit, replacing hand-written stimulus with a clocked, repeatable sweep.

---
 rtl/gate_sweep_ctrl.sv | 164 ++++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - sweep sequencer and truth-table checker for a 2-input NAND/NOR gate unit
module gate_sweep_ctrl #(
    parameter int SETTLE = 4,
    parameter int LOOPS  = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [1:0] i_gate_out,
    output logic       o_gate_a,
    output logic       o_gate_b,
    output logic [1:0] o_vec_idx,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_fail_mask,
    output logic [7:0] o_err_count
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [7:0] LOOP_LAST   = 8'(LOOPS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state, w_state_nx;
    logic [3:0] r_settle_cnt, w_settle_nx;
    logic [1:0] r_vec_idx, w_vec_nx;
    logic [7:0] r_loop, w_loop_nx;
    logic [3:0] r_fail_mask, w_mask_nx;
    logic [7:0] r_err_count, w_err_nx;
    logic       r_pass, w_pass_nx;
    logic       r_gate_a, w_gate_a_nx;
    logic       r_gate_b, w_gate_b_nx;
    logic [1:0] w_expected;
    logic       w_mismatch;
    logic [1:0] w_vec_inc;

    // bit0 = NAND, bit1 = NOR of (a,b) = (vec[1],vec[0])
    always_comb begin
        w_expected = 2'b00;
        case (r_vec_idx)
            2'd0:    w_expected = 2'b11;
            2'd1:    w_expected = 2'b01;
            2'd2:    w_expected = 2'b01;
            default: w_expected = 2'b00;
        endcase
    end

    assign w_mismatch = (i_gate_out != w_expected);
    assign w_vec_inc  = r_vec_idx + 2'd1;

    always_comb begin
        w_state_nx  = r_state;
        w_settle_nx = r_settle_cnt;
        w_vec_nx    = r_vec_idx;
        w_loop_nx   = r_loop;
        w_mask_nx   = r_fail_mask;
        w_err_nx    = r_err_count;
        w_pass_nx   = r_pass;
        w_gate_a_nx = r_gate_a;
        w_gate_b_nx = r_gate_b;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_state_nx  = S_DRIVE;
                    w_settle_nx = 4'd0;
                    w_vec_nx    = 2'd0;
                    w_loop_nx   = 8'd0;
                    w_mask_nx   = 4'd0;
                    w_err_nx    = 8'd0;
                    w_pass_nx   = 1'b0;
                    w_gate_a_nx = 1'b0;
                    w_gate_b_nx = 1'b0;
                end
            end
            S_DRIVE: begin
                if (i_abort) begin
                    w_state_nx  = S_IDLE;
                    w_gate_a_nx = 1'b0;
                    w_gate_b_nx = 1'b0;
                end else if (r_settle_cnt == SETTLE_LAST) begin
                    w_state_nx = S_CHECK;
                end else begin
                    w_settle_nx = r_settle_cnt + 4'd1;
                end
            end
            S_CHECK: begin
                if (i_abort) begin
                    w_state_nx  = S_IDLE;
                    w_gate_a_nx = 1'b0;
                    w_gate_b_nx = 1'b0;
                end else begin
                    if (w_mismatch) begin
                        w_mask_nx[r_vec_idx] = 1'b1;
                        if (r_err_count != 8'hFF)
                            w_err_nx = r_err_count + 8'd1;
                    end
                    w_settle_nx = 4'd0;
                    if (r_vec_idx != 2'd3) begin
                        w_state_nx  = S_DRIVE;
                        w_vec_nx    = w_vec_inc;
                        w_gate_a_nx = w_vec_inc[1];
                        w_gate_b_nx = w_vec_inc[0];
                    end else if (r_loop != LOOP_LAST) begin
                        w_state_nx  = S_DRIVE;
                        w_vec_nx    = 2'd0;
                        w_loop_nx   = r_loop + 8'd1;
                        w_gate_a_nx = 1'b0;
                        w_gate_b_nx = 1'b0;
                    end else begin
                        // pass must already reflect the final check while done is high
                        w_state_nx  = S_DONE;
                        w_pass_nx   = (w_err_nx == 8'd0);
                        w_gate_a_nx = 1'b0;
                        w_gate_b_nx = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= 4'd0;
            r_vec_idx    <= 2'd0;
            r_loop       <= 8'd0;
            r_fail_mask  <= 4'd0;
            r_err_count  <= 8'd0;
            r_pass       <= 1'b0;
            r_gate_a     <= 1'b0;
            r_gate_b     <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_settle_cnt <= w_settle_nx;
            r_vec_idx    <= w_vec_nx;
            r_loop       <= w_loop_nx;
            r_fail_mask  <= w_mask_nx;
            r_err_count  <= w_err_nx;
            r_pass       <= w_pass_nx;
            r_gate_a     <= w_gate_a_nx;
            r_gate_b     <= w_gate_b_nx;
        end
    end

    assign o_gate_a    = r_gate_a;
    assign o_gate_b    = r_gate_b;
    assign o_vec_idx   = r_vec_idx;
    assign o_busy      = (r_state == S_DRIVE) || (r_state == S_CHECK);
    assign o_done      = (r_state == S_DONE);
    assign o_pass      = r_pass;
    assign o_fail_mask = r_fail_mask;
    assign o_err_count = r_err_count;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - directed self-checking bench for gate_sweep_ctrl
`timescale 1ns/1ps
module tb_gate_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // fault modes: 0 ideal, 1 NOR stuck 0, 2 bits swapped, 3 all ones
    function automatic logic [1:0] gate_model(input logic [1:0] f, input logic a, input logic b);
        logic nand_v, nor_v;
        nand_v = ~(a & b);
        nor_v  = ~(a | b);
        case (f)
            2'd1:    return {1'b0, nand_v};
            2'd2:    return {nand_v, nor_v};
            2'd3:    return 2'b11;
            default: return {nor_v, nand_v};
        endcase
    endfunction

    logic       start1 = 0, abort1 = 0, start3 = 0, abort3 = 0, start255 = 0, abort255 = 0;
    logic [1:0] f1 = 0, f3 = 0, f255 = 0;
    logic [1:0] go1, go3, go255, vi1, vi3, vi255;
    logic       a1, b1, busy1, done1, pass1, a3, b3, busy3, done3, pass3;
    logic       a255, b255, busy255, done255, pass255;
    logic [3:0] m1, m3, m255;
    logic [7:0] e1, e3, e255;

    assign go1   = gate_model(f1, a1, b1);
    assign go3   = gate_model(f3, a3, b3);
    assign go255 = gate_model(f255, a255, b255);

    gate_sweep_ctrl #(.SETTLE(2), .LOOPS(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_abort(abort1), .i_gate_out(go1),
        .o_gate_a(a1), .o_gate_b(b1), .o_vec_idx(vi1), .o_busy(busy1), .o_done(done1),
        .o_pass(pass1), .o_fail_mask(m1), .o_err_count(e1));

    gate_sweep_ctrl #(.SETTLE(2), .LOOPS(3)) u3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .i_abort(abort3), .i_gate_out(go3),
        .o_gate_a(a3), .o_gate_b(b3), .o_vec_idx(vi3), .o_busy(busy3), .o_done(done3),
        .o_pass(pass3), .o_fail_mask(m3), .o_err_count(e3));

    gate_sweep_ctrl #(.SETTLE(1), .LOOPS(255)) u255 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start255), .i_abort(abort255), .i_gate_out(go255),
        .o_gate_a(a255), .o_gate_b(b255), .o_vec_idx(vi255), .o_busy(busy255), .o_done(done255),
        .o_pass(pass255), .o_fail_mask(m255), .o_err_count(e255));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #12;
        check("rst_busy", {15'd0, busy1}, 16'd0);
        check("rst_done", {15'd0, done1}, 16'd0);
        check("rst_pass", {15'd0, pass1}, 16'd0);
        check("rst_ab", {14'd0, a1, b1}, 16'd0);
        check("rst_vec", {14'd0, vi1}, 16'd0);
        check("rst_mask", {12'd0, m1}, 16'd0);
        check("rst_err", {8'd0, e1}, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // ideal run, SETTLE=2 LOOPS=1: 12 busy cycles, done in cycle 13
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            int v;
            v = c / 3;
            check("t1_busy", {15'd0, busy1}, 16'd1);
            check("t1_done_low", {15'd0, done1}, 16'd0);
            check("t1_ab", {14'd0, a1, b1}, 16'(v));
            check("t1_vec", {14'd0, vi1}, 16'(v));
            tick();
        end
        check("t1_done", {15'd0, done1}, 16'd1);
        check("t1_busy_done", {15'd0, busy1}, 16'd0);
        check("t1_pass", {15'd0, pass1}, 16'd1);
        check("t1_mask", {12'd0, m1}, 16'd0);
        check("t1_err", {8'd0, e1}, 16'd0);
        check("t1_ab_done", {14'd0, a1, b1}, 16'd0);
        tick();
        check("t1_done_pulse", {15'd0, done1}, 16'd0);
        check("t1_pass_hold", {15'd0, pass1}, 16'd1);

        // NOR stuck at 0, LOOPS=3
        f3 = 2'd1;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done3) break;
            tick();
        end
        check("t2_done", {15'd0, done3}, 16'd1);
        check("t2_pass", {15'd0, pass3}, 16'd0);
        check("t2_mask", {12'd0, m3}, 16'h1);
        check("t2_err", {8'd0, e3}, 16'd3);

        // swapped outputs, LOOPS=1
        f1 = 2'd2;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("t3_pass_clr", {15'd0, pass1}, 16'd0);
        for (int k = 0; k < 50; k++) begin
            if (done1) break;
            tick();
        end
        check("t3_done", {15'd0, done1}, 16'd1);
        check("t3_pass", {15'd0, pass1}, 16'd0);
        check("t3_mask", {12'd0, m1}, 16'h6);
        check("t3_err", {8'd0, e1}, 16'd2);
        tick();
        check("t3_mask_hold", {12'd0, m1}, 16'h6);

        // all ones, LOOPS=255: 765 mismatches saturate at 255
        f255 = 2'd3;
        start255 = 1'b1;
        tick();
        start255 = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (done255) break;
            tick();
        end
        check("t4_done", {15'd0, done255}, 16'd1);
        check("t4_pass", {15'd0, pass255}, 16'd0);
        check("t4_mask", {12'd0, m255}, 16'hE);
        check("t4_err", {8'd0, e255}, 16'd255);

        // abort during vector 2 DRIVE; start mid-run ignored
        tick();
        f1 = 2'd0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("t5_start_ignored", {14'd0, vi1}, 16'd1);
        tick();
        tick();
        tick();
        check("t5_in_vec2", {14'd0, vi1}, 16'd2);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        check("t5_busy", {15'd0, busy1}, 16'd0);
        check("t5_ab", {14'd0, a1, b1}, 16'd0);
        check("t5_pass", {15'd0, pass1}, 16'd0);
        for (int k = 0; k < 16; k++) begin
            check("t5_no_done", {15'd0, done1}, 16'd0);
            tick();
        end

        // start with abort in IDLE: no run
        start1 = 1'b1;
        abort1 = 1'b1;
        tick();
        check("t6_busy", {15'd0, busy1}, 16'd0);
        tick();
        start1 = 1'b0;
        abort1 = 1'b0;
        check("t6_busy2", {15'd0, busy1}, 16'd0);
        tick();
        check("t6_busy3", {15'd0, busy1}, 16'd0);

        // asynchronous reset during vector 2 CHECK, after one mismatch on vector 1
        f1 = 2'd3;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("t7_pre_busy", {15'd0, busy1}, 16'd1);
        check("t7_pre_err", {8'd0, e1}, 16'd1);
        check("t7_pre_mask", {12'd0, m1}, 16'h2);
        rst_n = 1'b0;
        #1;
        check("t7_busy", {15'd0, busy1}, 16'd0);
        check("t7_ab", {14'd0, a1, b1}, 16'd0);
        check("t7_vec", {14'd0, vi1}, 16'd0);
        check("t7_mask", {12'd0, m1}, 16'd0);
        check("t7_err", {8'd0, e1}, 16'd0);
        check("t7_pass_done", {14'd0, pass1, done1}, 16'd0);
        tick();
        rst_n = 1'b1;
        f1 = 2'd0;
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (done1) break;
            tick();
        end
        check("t7_done", {15'd0, done1}, 16'd1);
        check("t7_pass", {15'd0, pass1}, 16'd1);
        check("t7_mask_post", {12'd0, m1}, 16'd0);
        check("t7_err_post", {8'd0, e1}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
